fft_window: RTL and testbench

Input windowing and framing stage that sits directly upstream of the FFT capture RAM. It accepts a gapless stream of signed samples, multiplies each by a Hann (or rectangular, in bypass) coefficient selected by its position in the frame, and drives the capture RAM's write stream. The RAM's write strobe is active-low, so `fft_wren` is low while a frame is being written. After the last sample of a complete frame it issues the one-cycle arm pulse that hands the frame to readout. Frames interrupted by a gap are aborted and flagged.

---
 rtl/fft_window.sv | 180 ++++++++++++++++++
 tb/tb_fft_window.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_window.sv
// rtl/fft_window.sv - Hann windowing and framing stage feeding the FFT capture RAM
module fft_window #(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 1024,
    parameter int COEF_WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             bypass,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] fft_wrdata,
    output logic             fft_wren,
    output logic             fft_arm_read,
    output logic             frame_err,
    output logic [15:0]      frame_cnt
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = WIDTH + COEF_WIDTH + 1;
    localparam logic [COEF_WIDTH-1:0] BYP_COEF = {1'b1, {(COEF_WIDTH-1){1'b0}}};
    localparam logic signed [PW-1:0]  RND      = PW'(64'sd1 <<< (COEF_WIDTH-2));
    localparam logic signed [PW-1:0]  SAT_MAX  = PW'((64'sd1 <<< (WIDTH-1)) - 64'sd1);
    localparam logic signed [PW-1:0]  SAT_MIN  = -SAT_MAX - PW'(1);

    typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_DRAIN, ST_ARM} state_t;

    // Hann coefficient, rounded half away from zero (values are never negative)
    function automatic logic [COEF_WIDTH-1:0] hann_coef(input int n);
        real x;
        x = (2.0 ** (COEF_WIDTH - 1) - 1.0) * 0.5
            * (1.0 - $cos(2.0 * 3.14159265358979323846 * n / DEPTH));
        return COEF_WIDTH'($rtoi(x + 0.5));
    endfunction

    logic [COEF_WIDTH-1:0] w_rom [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_rom
        assign w_rom[g] = hann_coef(g);
    end

    state_t                  r_state;
    logic [IW-1:0]           r_idx;
    logic                    r_bypass;
    logic                    r_arm;
    logic                    r_err;
    logic [15:0]             r_frame_cnt;

    logic                    r_v1;
    logic signed [WIDTH-1:0] r_s1;
    logic [COEF_WIDTH-1:0]   r_c1;
    logic                    r_v2;
    logic signed [PW-1:0]    r_p2;
    logic                    r_wren;
    logic [WIDTH-1:0]        r_wrdata;

    logic                    w_hs;
    logic                    w_abort;
    logic                    w_byp_now;
    logic [COEF_WIDTH-1:0]   w_coef;
    logic signed [PW-1:0]    w_prod;
    logic signed [PW-1:0]    w_shift;
    logic [WIDTH-1:0]        w_sat;

    // rst_n gates the ready so it reads 0 the instant reset asserts
    assign in_ready  = rst_n & (((r_state == ST_IDLE) & ena) | (r_state == ST_FILL));
    assign w_hs      = in_valid & in_ready;
    assign w_abort   = ((r_state == ST_FILL)  & (~in_valid | ~ena))
                     | ((r_state == ST_DRAIN) & ~ena);
    // the first sample of a frame uses the live bypass, later ones the latched copy
    assign w_byp_now = (r_state == ST_IDLE) ? bypass : r_bypass;
    assign w_coef    = w_byp_now ? BYP_COEF : w_rom[r_idx];
    assign w_prod    = r_s1 * $signed({1'b0, r_c1});
    assign w_shift   = (r_p2 + RND) >>> (COEF_WIDTH - 1);

    // round-half-up result clipped to the output range
    always_comb begin
        w_sat = w_shift[WIDTH-1:0];
        if (w_shift > SAT_MAX) begin
            w_sat = SAT_MAX[WIDTH-1:0];
        end else if (w_shift < SAT_MIN) begin
            w_sat = SAT_MIN[WIDTH-1:0];
        end
    end

    // frame control: index, bypass latch, arm/err pulses and frame counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_bypass    <= 1'b0;
            r_arm       <= 1'b0;
            r_err       <= 1'b0;
            r_frame_cnt <= 16'd0;
        end else begin
            r_arm <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_hs) begin
                        r_state  <= ST_FILL;
                        r_bypass <= bypass;
                        r_idx    <= IW'(1);
                    end
                end
                ST_FILL: begin
                    if (w_abort) begin
                        r_state <= ST_IDLE;
                        r_idx   <= '0;
                        r_err   <= 1'b1;
                    end else if (r_idx == IW'(DEPTH - 1)) begin
                        r_state <= ST_DRAIN;
                        r_idx   <= '0;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (w_abort) begin
                        r_state <= ST_IDLE;
                        r_err   <= 1'b1;
                    end else if (!r_v1 && !r_v2 && !r_wren) begin
                        // last sample is on the RAM port now; arm right after it
                        r_state     <= ST_ARM;
                        r_arm       <= 1'b1;
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                    end
                end
                ST_ARM: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // three-stage datapath: capture+ROM, multiply, round/saturate to RAM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1     <= 1'b0;
            r_s1     <= '0;
            r_c1     <= '0;
            r_v2     <= 1'b0;
            r_p2     <= '0;
            r_wren   <= 1'b1;
            r_wrdata <= '0;
        end else begin
            if (w_abort) begin
                r_v1   <= 1'b0;
                r_v2   <= 1'b0;
                r_wren <= 1'b1;
            end else begin
                r_v1   <= w_hs;
                r_v2   <= r_v1;
                r_wren <= ~r_v2;
            end
            if (w_hs) begin
                r_s1 <= $signed(in_data);
                r_c1 <= w_coef;
            end
            if (r_v1) begin
                r_p2 <= w_prod;
            end
            if (r_v2) begin
                r_wrdata <= w_sat;
            end
        end
    end

    assign fft_wrdata   = r_wrdata;
    assign fft_wren     = r_wren;
    assign fft_arm_read = r_arm;
    assign frame_err    = r_err;
    assign frame_cnt    = r_frame_cnt;

endmodule

// File: tb/tb_fft_window.sv
// tb/tb_fft_window.sv - scoreboard bench for fft_window with a real-arithmetic window model
module tb_fft_window;

    localparam int W  = 16;
    localparam int D  = 8;
    localparam int CW = 16;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                ena = 1'b1;
    logic                bypass = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [W-1:0]        in_data = '0;
    logic signed [W-1:0] fft_wrdata;
    logic                fft_wren;
    logic                fft_arm_read;
    logic                frame_err;
    logic [15:0]         frame_cnt;

    always #5 clk = ~clk;

    fft_window #(.WIDTH(W), .DEPTH(D), .COEF_WIDTH(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .bypass       (bypass),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .fft_wrdata   (fft_wrdata),
        .fft_wren     (fft_wren),
        .fft_arm_read (fft_arm_read),
        .frame_err    (frame_err),
        .frame_cnt    (frame_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int exp_q[$];
    int arm_q[$];
    int fixed_exp[$];
    int err_seen  = 0;
    int arm_seen  = 0;
    int model_cnt = 0;
    int idx       = 0;
    bit frm_byp   = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int model_coef(input int n, input bit byp);
        if (byp) return 32768;
        return $rtoi(32767.0 * 0.5 * (1.0 - $cos(2.0 * 3.14159265358979323846 * n / D)) + 0.5);
    endfunction

    function automatic int model_win(input int x, input int n, input bit byp);
        real r;
        int  y;
        r = real'(x) * real'(model_coef(n, byp)) / 32768.0;
        y = $rtoi($floor(r + 0.5));
        if (y > 32767)  y = 32767;
        if (y < -32768) y = -32768;
        return y;
    endfunction

    function automatic int rnd16();
        logic signed [15:0] t;
        t = 16'($urandom);
        return int'(t);
    endfunction

    // one cycle of stimulus; the model records what a handshake should produce
    task automatic send(input int x, input bit byp, output bit hs);
        int e;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = W'(x);
        bypass   = byp;
        #1 hs = in_ready;
        @(posedge clk);
        if (hs) begin
            if (idx == 0) frm_byp = byp;
            if (fixed_exp.size() > 0) e = fixed_exp.pop_front();
            else e = model_win(x, idx, frm_byp);
            exp_q.push_back(e);
            idx++;
            if (idx == D) begin
                idx = 0;
                model_cnt = (model_cnt + 1) & 16'hFFFF;
                arm_q.push_back(model_cnt);
            end
        end
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic send_frame(input int n4, input bit use_n4, input bit byp);
        bit hs;
        for (int i = 0; i < D; i++) begin
            send((use_n4 && i == 4) ? n4 : rnd16(), byp, hs);
            check("frame_hs", int'(hs), 1);
        end
    endtask

    // monitor: every RAM write and every arm pulse is matched against the queues
    always @(negedge clk) begin
        if (rst_n) begin
            if (!fft_wren) begin
                if (exp_q.size() == 0) check("unexpected_sample", 1, 0);
                else check("wrdata", int'(fft_wrdata), exp_q.pop_front());
            end
            if (fft_arm_read) begin
                arm_seen++;
                check("arm_wren_high", int'(fft_wren), 1);
                check("arm_pipe_empty", exp_q.size(), 0);
                if (arm_q.size() == 0) check("unexpected_arm", 1, 0);
                else check("frame_cnt_at_arm", int'(frame_cnt), arm_q.pop_front());
            end
            if (frame_err) err_seen++;
        end
    end

    initial begin
        bit hs;
        int lowrun;
        int acc;
        int gaps[$];
        int e0;
        int a0;
        int c0;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_wren", int'(fft_wren), 1);
        check("rst_wrdata", int'(fft_wrdata), 0);
        check("rst_arm", int'(fft_arm_read), 0);
        check("rst_err", int'(frame_err), 0);
        check("rst_cnt", int'(frame_cnt), 0);
        check("rst_ready", int'(in_ready), 0);
        rst_n = 1'b1;

        // constant 1000 through the Hann window, with drain/arm timing
        fixed_exp = '{0, 146, 500, 854, 1000, 854, 500, 146};
        for (int i = 0; i < D; i++) send(1000, 1'b0, hs);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (i == 1) in_valid = 1'b0;
            check("drain_ready", int'(in_ready), (i == 5) ? 1 : 0);
            check("drain_arm", int'(fft_arm_read), (i == 4) ? 1 : 0);
        end
        check("cnt_after_first", int'(frame_cnt), 1);

        // bypass ramp passes through unchanged
        for (int i = -4; i < 4; i++) send(i, 1'b1, hs);
        idle(5);

        // multiplier extremes at the window peak
        send_frame(-32768, 1'b1, 1'b0);
        idle(5);
        send_frame(32767, 1'b1, 1'b0);
        idle(5);

        // back-to-back frames with in_valid held high and bypass toggling
        lowrun = 0;
        acc = 0;
        for (int cyc = 0; cyc < 60 && acc < 2 * D; cyc++) begin
            send(rnd16(), 1'($urandom), hs);
            if (hs) begin
                if (acc > 0 && lowrun > 0) gaps.push_back(lowrun);
                lowrun = 0;
                acc++;
            end else begin
                lowrun++;
            end
        end
        check("b2b_accepted", acc, 2 * D);
        check("b2b_gap_count", gaps.size(), 1);
        if (gaps.size() > 0) check("b2b_gap_len", gaps[0], 4);
        idle(6);
        check("b2b_cnt", int'(frame_cnt), model_cnt);

        // in_valid drops at index 5
        e0 = err_seen;
        a0 = arm_seen;
        c0 = model_cnt;
        for (int i = 0; i < 5; i++) send(rnd16(), 1'b0, hs);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("abort_err_pulse", int'(frame_err), 1);
        check("abort_wren", int'(fft_wren), 1);
        @(negedge clk);
        check("abort_err_once", int'(frame_err), 0);
        check("abort_wren_hold", int'(fft_wren), 1);
        idle(5);
        check("abort_err_count", err_seen - e0, 1);
        check("abort_dropped", exp_q.size(), 2);
        check("abort_no_arm", arm_seen - a0, 0);
        check("abort_cnt", int'(frame_cnt), c0);
        exp_q.delete();
        idx = 0;

        // next frame starts cleanly at index 0
        send_frame(0, 1'b0, 1'($urandom));
        idle(5);

        // ena drops in DRAIN
        e0 = err_seen;
        a0 = arm_seen;
        c0 = model_cnt;
        send_frame(0, 1'b0, 1'b0);
        @(negedge clk);
        ena = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("drain_abort_err", int'(frame_err), 1);
        idle(5);
        check("drain_abort_err_count", err_seen - e0, 1);
        check("drain_abort_dropped", exp_q.size(), 2);
        check("drain_abort_no_arm", arm_seen - a0, 0);
        check("drain_abort_cnt", int'(frame_cnt), c0);
        exp_q.delete();
        arm_q.delete();
        model_cnt = c0;
        ena = 1'b1;

        // reset in the middle of FILL
        e0 = err_seen;
        for (int i = 0; i < 4; i++) send(rnd16(), 1'b0, hs);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_wren", int'(fft_wren), 1);
        check("midrst_wrdata", int'(fft_wrdata), 0);
        check("midrst_arm", int'(fft_arm_read), 0);
        check("midrst_err", int'(frame_err), 0);
        check("midrst_cnt", int'(frame_cnt), 0);
        check("midrst_ready", int'(in_ready), 0);
        in_valid = 1'b0;
        exp_q.delete();
        arm_q.delete();
        idx = 0;
        model_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(4);
        check("midrst_no_err", err_seen - e0, 0);

        // frame counter wrap
        @(negedge clk);
        force dut.r_frame_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.r_frame_cnt;
        model_cnt = 16'hFFFF;
        check("preload_cnt", int'(frame_cnt), 16'hFFFF);
        send_frame(0, 1'b0, 1'b0);
        idle(6);
        check("wrap_cnt", int'(frame_cnt), 0);

        idle(4);
        check("final_exp_empty", exp_q.size(), 0);
        check("final_arm_empty", arm_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
